// File: rtl/modular_inverse_fp_pkg.sv
// Shared types for the prime-field inverter: FSM state encoding and the default curve prime.
package modular_inverse_fp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_HALVE_U,
        ST_HALVE_V,
        ST_SUB,
        ST_FINISH
    } inv_state_t;

    // secp256k1 field prime, used by default-curve benches
    localparam logic [255:0] SECP256K1_P =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

endpackage

// File: rtl/modular_inverse_fp_if.sv
// Request/response bundle of the modular inverter: operand and modulus in, result and status out.
interface modular_inverse_fp_if #(
    parameter int WIDTH = 256
);
    logic             start;
    logic [WIDTH-1:0] in;
    logic [WIDTH-1:0] mod_p;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] out;
    logic             err;

    modport master (output start, in, mod_p, input busy, done, out, err);
    modport slave  (input start, in, mod_p, output busy, done, out, err);
endinterface

// File: rtl/modular_inverse_fp_mod_half.sv
// Combinational x/2 mod p for odd p: odd x is made even by adding p in WIDTH+1 bits first.
module mod_half #(
    parameter int WIDTH = 256
) (
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] p_i,
    output logic [WIDTH-1:0] y_o
);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] sel;

    assign sum = {1'b0, x_i} + {1'b0, p_i};
    assign sel = x_i[0] ? sum : {1'b0, x_i};
    assign y_o = WIDTH'(sel >> 1);
endmodule

// File: rtl/modular_inverse_fp.sv
// Binary extended Euclidean inverter over a run-time odd modulus; x1*a==u and x2*a==v (mod p) hold throughout.
module modular_inverse_fp
    import modular_inverse_fp_pkg::*;
#(
    parameter int WIDTH = 256
) (
    input  logic               clk,
    input  logic               Reset_n,
    modular_inverse_fp_if.slave bus
);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    inv_state_t       state_q;
    logic [WIDTH-1:0] u_q, v_q, x1_q, x2_q, p_q, out_q;
    logic             busy_q, done_q, err_q, fail_q;

    logic [WIDTH-1:0] x1_half, x2_half;
    logic [WIDTH:0]   x1_sub_x2, x2_sub_x1;
    logic [WIDTH-1:0] x1_minus, x2_minus;
    logic             illegal;

    assign illegal = (bus.in == '0) || (bus.in >= bus.mod_p) ||
                     !bus.mod_p[0] || (bus.mod_p < WIDTH'(3));

    // Borrow out of the extra bit means the difference went negative: fold back by adding p
    assign x1_sub_x2 = {1'b0, x1_q} - {1'b0, x2_q};
    assign x2_sub_x1 = {1'b0, x2_q} - {1'b0, x1_q};
    assign x1_minus  = x1_sub_x2[WIDTH] ? x1_sub_x2[WIDTH-1:0] + p_q : x1_sub_x2[WIDTH-1:0];
    assign x2_minus  = x2_sub_x1[WIDTH] ? x2_sub_x1[WIDTH-1:0] + p_q : x2_sub_x1[WIDTH-1:0];

    mod_half #(.WIDTH(WIDTH)) u_half_x1 (.x_i(x1_q), .p_i(p_q), .y_o(x1_half));
    mod_half #(.WIDTH(WIDTH)) u_half_x2 (.x_i(x2_q), .p_i(p_q), .y_o(x2_half));

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
            u_q     <= '0;
            v_q     <= '0;
            x1_q    <= '0;
            x2_q    <= '0;
            p_q     <= '0;
            out_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        p_q     <= bus.mod_p;
                        u_q     <= bus.in;
                        v_q     <= bus.mod_p;
                        x1_q    <= ONE;
                        x2_q    <= '0;
                        busy_q  <= 1'b1;
                        fail_q  <= illegal;
                        state_q <= illegal ? ST_FINISH : ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (u_q == ONE || v_q == ONE) begin
                        fail_q  <= 1'b0;
                        state_q <= ST_FINISH;
                    end else if (u_q == '0 || v_q == '0) begin
                        fail_q  <= 1'b1;
                        state_q <= ST_FINISH;
                    end else if (!u_q[0]) begin
                        state_q <= ST_HALVE_U;
                    end else if (!v_q[0]) begin
                        state_q <= ST_HALVE_V;
                    end else begin
                        state_q <= ST_SUB;
                    end
                end
                ST_HALVE_U: begin
                    u_q  <= u_q >> 1;
                    x1_q <= x1_half;
                    // u_q[1] is the parity of the halved u
                    if (u_q[1]) begin
                        state_q <= v_q[0] ? ST_SUB : ST_HALVE_V;
                    end
                end
                ST_HALVE_V: begin
                    v_q  <= v_q >> 1;
                    x2_q <= x2_half;
                    if (v_q[1]) begin
                        state_q <= ST_SUB;
                    end
                end
                ST_SUB: begin
                    if (u_q >= v_q) begin
                        u_q  <= u_q - v_q;
                        x1_q <= x1_minus;
                    end else begin
                        v_q  <= v_q - u_q;
                        x2_q <= x2_minus;
                    end
                    state_q <= ST_CHECK;
                end
                ST_FINISH: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    err_q   <= fail_q;
                    out_q   <= fail_q ? '0 : ((u_q == ONE) ? x1_q : x2_q);
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.out  = out_q;
    assign bus.err  = err_q;
endmodule

// File: tb/tb_modular_inverse_fp.sv
// Directed bench for the modular inverter: an 8-bit instance for small primes and a 256-bit secp256k1 instance.
module tb_modular_inverse_fp;
    import modular_inverse_fp_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    modular_inverse_fp_if #(.WIDTH(8))   if8 ();
    modular_inverse_fp_if #(.WIDTH(256)) if256 ();

    modular_inverse_fp #(.WIDTH(8))   dut8   (.clk(clk), .Reset_n(rst_n), .bus(if8));
    modular_inverse_fp #(.WIDTH(256)) dut256 (.clk(clk), .Reset_n(rst_n), .bus(if256));

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called #1 after a rising edge with the DUT idle; cyc counts edges from the sampling edge to done.
    task automatic run8(input logic [7:0] a, input logic [7:0] p,
                        output logic [7:0] o, output logic e, output int cyc);
        if8.start = 1'b1;
        if8.in    = a;
        if8.mod_p = p;
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            if8.start = 1'b0;
            cyc++;
        end while (!if8.done && cyc < 100);
        chk("done8", 256'(if8.done), 256'd1);
        o = if8.out;
        e = if8.err;
        $display("w8  a=%0d p=%0d -> out=%0d err=%0b cycles=%0d", a, p, o, e, cyc);
    endtask

    task automatic run256(input logic [255:0] a, output logic [255:0] o,
                          output logic e, output int cyc);
        if256.start = 1'b1;
        if256.in    = a;
        if256.mod_p = SECP256K1_P;
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            if256.start = 1'b0;
            cyc++;
        end while (!if256.done && cyc < 1200);
        chk("done256", 256'(if256.done), 256'd1);
        o = if256.out;
        e = if256.err;
        $display("w256 a=%0h -> out=%0h err=%0b cycles=%0d", a, o, e, cyc);
    endtask

    function automatic logic [255:0] mulmod(input logic [255:0] x, input logic [255:0] y);
        logic [511:0] prod;
        prod = {256'd0, x} * {256'd0, y};
        return 256'(prod % {256'd0, SECP256K1_P});
    endfunction

    logic [7:0]   o8;
    logic [255:0] o256, a256;
    logic         e;
    int           cyc;

    initial begin
        logic [7:0] bad_a [4];
        logic [7:0] bad_p [4];
        bad_a = '{8'd0, 8'd23, 8'd40, 8'd5};
        bad_p = '{8'd23, 8'd23, 8'd23, 8'd22};

        rst_n = 1'b0;
        if8.start = 1'b0;   if8.in = '0;   if8.mod_p = '0;
        if256.start = 1'b0; if256.in = '0; if256.mod_p = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 256'(if8.busy), 256'd0);
        chk("rst_done", 256'(if8.done), 256'd0);
        chk("rst_out",  256'(if8.out),  256'd0);
        chk("rst_err",  256'(if8.err),  256'd0);
        chk("rst_busy256", 256'(if256.busy), 256'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run8(8'd3, 8'd23, o8, e, cyc);
        chk("inv3_out", 256'(o8), 256'd8);
        chk("inv3_err", 256'(e), 256'd0);

        run8(8'd1, 8'd23, o8, e, cyc);
        chk("inv1_out", 256'(o8), 256'd1);
        chk("inv1_cyc", 256'(cyc), 256'd3);

        run8(8'd22, 8'd23, o8, e, cyc);
        chk("inv22_out", 256'(o8), 256'd22);

        for (int a = 1; a <= 22; a++) begin
            run8(8'(a), 8'd23, o8, e, cyc);
            chk("sweep_prod", 256'((int'(o8) * a) % 23), 256'd1);
            chk("sweep_err", 256'(e), 256'd0);
        end

        for (int i = 0; i < 4; i++) begin
            run8(bad_a[i], bad_p[i], o8, e, cyc);
            chk("illegal_err", 256'(e), 256'd1);
            chk("illegal_out", 256'(o8), 256'd0);
            chk("illegal_cyc", 256'(cyc), 256'd2);
        end

        run8(8'd5, 8'd15, o8, e, cyc);
        chk("gcd5_err", 256'(e), 256'd1);
        chk("gcd5_out", 256'(o8), 256'd0);
        run8(8'd7, 8'd15, o8, e, cyc);
        chk("inv7_15_out", 256'(o8), 256'd13);
        chk("inv7_15_err", 256'(e), 256'd0);

        // Second start while busy must not disturb the first request
        if8.start = 1'b1; if8.in = 8'd3; if8.mod_p = 8'd23;
        @(posedge clk); #1;
        if8.start = 1'b0;
        chk("busy_high", 256'(if8.busy), 256'd1);
        @(posedge clk); #1;
        if8.start = 1'b1; if8.in = 8'd5;
        @(posedge clk); #1;
        if8.start = 1'b0;
        for (int i = 0; i < 100 && !if8.done; i++) begin
            @(posedge clk); #1;
        end
        chk("ign_done", 256'(if8.done), 256'd1);
        chk("ign_out", 256'(if8.out), 256'd8);
        chk("ign_busy", 256'(if8.busy), 256'd0);
        $display("w8  ignored-start run -> out=%0d", if8.out);
        repeat (3) @(posedge clk);
        #1;
        chk("hold_out", 256'(if8.out), 256'd8);
        chk("hold_done", 256'(if8.done), 256'd0);

        run256(256'd2, o256, e, cyc);
        chk("k1_inv2_out", o256, (SECP256K1_P + 256'd1) >> 1);
        chk("k1_inv2_err", 256'(e), 256'd0);
        chk("k1_inv2_lat", 256'(cyc <= 1028), 256'd1);

        for (int i = 0; i < 16; i++) begin
            a256 = {$urandom, $urandom, $urandom, $urandom,
                    $urandom, $urandom, $urandom, $urandom};
            a256 = a256 % SECP256K1_P;
            if (a256 == '0) a256 = 256'd1;
            run256(a256, o256, e, cyc);
            chk("k1_rand_prod", mulmod(o256, a256), 256'd1);
            chk("k1_rand_lat", 256'(cyc <= 1028), 256'd1);
        end

        // Reset in the middle of a long computation
        if256.start = 1'b1; if256.in = 256'd12345; if256.mod_p = SECP256K1_P;
        @(posedge clk); #1;
        if256.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("mid_busy_pre", 256'(if256.busy), 256'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 256'(if256.busy), 256'd0);
        chk("mid_rst_done", 256'(if256.done), 256'd0);
        chk("mid_rst_out",  if256.out,        256'd0);
        chk("mid_rst_err",  256'(if256.err),  256'd0);
        chk("mid_rst_out8", 256'(if8.out),    256'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run256(256'd2, o256, e, cyc);
        chk("post_rst_out", o256, (SECP256K1_P + 256'd1) >> 1);
        chk("post_rst_err", 256'(e), 256'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
